// File: rtl/channel_extractor_pipe_if.sv
// Pixel stream bundle for channel_extractor_pipe: packed-pixel input side and single-plane output side.
// CHX_THRESH_EN adds the per-beat threshold input and the binarised output.
interface channel_extractor_pipe_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int SEL_W  = 3
);
    logic                     s_valid;
    logic                     s_ready;
    logic [NUM_CH*DATA_W-1:0] s_data;
    logic [SEL_W-1:0]         s_sel;
    logic [1:0]               s_mode;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic                     m_last;
`ifdef CHX_THRESH_EN
    logic [DATA_W-1:0]        thresh;
    logic                     m_bin;

    modport master (
        output s_valid, s_data, s_sel, s_mode, s_last, thresh, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_bin
    );
    modport slave (
        input  s_valid, s_data, s_sel, s_mode, s_last, thresh, m_ready,
        output s_ready, m_valid, m_data, m_last, m_bin
    );
`else
    modport master (
        output s_valid, s_data, s_sel, s_mode, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
    modport slave (
        input  s_valid, s_data, s_sel, s_mode, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
`endif
endinterface

// File: rtl/channel_extractor_pipe.sv
// Two-stage channel extractor: select / max / min / inverted-select of packed pixel channels, 1 pixel/clk.
// Optional CHX_THRESH_EN adds a registered binarised output m_bin = (result >= thresh).
module channel_extractor_pipe #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    channel_extractor_pipe_if.slave bus,
    output logic [CNT_W-1:0]       pix_count,
    output logic                   sel_err
);
    localparam logic [SEL_W:0] NUM_CH_S = (SEL_W+1)'(NUM_CH);

    logic              adv;
    logic              in_fire;
    logic              out_fire;
    logic [DATA_W-1:0] sel_ch;
    logic [DATA_W-1:0] max_ch;
    logic [DATA_W-1:0] min_ch;
    logic              sel_oob;
    logic              uses_sel;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_ch;
    logic [DATA_W-1:0] s1_max;
    logic [DATA_W-1:0] s1_min;
    logic [1:0]        s1_mode;
    logic              s1_oob;
    logic              s1_last;
    logic [DATA_W-1:0] result;
`ifdef CHX_THRESH_EN
    logic [DATA_W-1:0] s1_thresh;
`endif

    // Whole pipeline moves together; bubbles are overwritten whenever the output slot is free.
    assign adv         = bus.m_ready || !bus.m_valid;
    assign bus.s_ready = adv;
    assign in_fire     = bus.s_valid && adv;
    assign out_fire    = bus.m_valid && bus.m_ready;

    assign sel_oob  = ({1'b0, bus.s_sel} >= NUM_CH_S);
    assign uses_sel = (bus.s_mode == 2'b00) || (bus.s_mode == 2'b11);

    always_comb begin
        sel_ch = '0;
        max_ch = bus.s_data[DATA_W-1:0];
        min_ch = bus.s_data[DATA_W-1:0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.s_sel == SEL_W'(k))
                sel_ch = bus.s_data[k*DATA_W +: DATA_W];
            if (bus.s_data[k*DATA_W +: DATA_W] > max_ch)
                max_ch = bus.s_data[k*DATA_W +: DATA_W];
            if (bus.s_data[k*DATA_W +: DATA_W] < min_ch)
                min_ch = bus.s_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_max    <= '0;
            s1_min    <= '0;
            s1_mode   <= 2'b00;
            s1_oob    <= 1'b0;
            s1_last   <= 1'b0;
            sel_err   <= 1'b0;
`ifdef CHX_THRESH_EN
            s1_thresh <= '0;
`endif
        end else begin
            if (adv)
                s1_valid <= bus.s_valid;
            if (in_fire) begin
                s1_ch     <= sel_ch;
                s1_max    <= max_ch;
                s1_min    <= min_ch;
                s1_mode   <= bus.s_mode;
                s1_oob    <= sel_oob;
                s1_last   <= bus.s_last;
`ifdef CHX_THRESH_EN
                s1_thresh <= bus.thresh;
`endif
            end
            if (in_fire && uses_sel && sel_oob)
                sel_err <= 1'b1;
        end
    end

    // An out-of-range select yields 0 in both select and invert modes, never ~0.
    always_comb begin
        result = '0;
        case (s1_mode)
            2'b00:   result = s1_oob ? '0 : s1_ch;
            2'b01:   result = s1_max;
            2'b10:   result = s1_min;
            default: result = s1_oob ? '0 : ~s1_ch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
`ifdef CHX_THRESH_EN
            bus.m_bin   <= 1'b0;
`endif
        end else if (adv) begin
            bus.m_valid <= s1_valid;
            if (s1_valid) begin
                bus.m_data <= result;
                bus.m_last <= s1_last;
`ifdef CHX_THRESH_EN
                bus.m_bin  <= (result >= s1_thresh);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pix_count <= '0;
        else if (out_fire)
            pix_count <= bus.m_last ? '0 : pix_count + 1'b1;
    end
endmodule

// File: tb/tb_channel_extractor_pipe.sv
// Self-checking bench for channel_extractor_pipe (NUM_CH=3, DATA_W=8); define CHX_THRESH_EN to cover m_bin.
`timescale 1ns/1ps
module tb_channel_extractor_pipe;
    localparam int DATA_W = 8;
    localparam int NUM_CH = 3;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] pix_count;
    logic             sel_err;
    int checks = 0;
    int errors = 0;

    channel_extractor_pipe_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

    channel_extractor_pipe #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pix_count (pix_count),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    // (r,g,b) = (255,128,64) with r on channel 0
    localparam logic [23:0] PIX = {8'd64, 8'd128, 8'd255};

    function automatic logic [7:0] ref_result(input logic [23:0] d, input int sel, input int mode);
        int ch[3];
        int r;
        for (int i = 0; i < 3; i++) ch[i] = int'(d[i*8 +: 8]);
        case (mode)
            0: r = (sel < 3) ? ch[sel] : 0;
            1: begin r = ch[0]; for (int i = 1; i < 3; i++) if (ch[i] > r) r = ch[i]; end
            2: begin r = ch[0]; for (int i = 1; i < 3; i++) if (ch[i] < r) r = ch[i]; end
            default: r = (sel < 3) ? 255 - ch[sel] : 0;
        endcase
        return 8'(r);
    endfunction

    // Starts and ends 1ns after a rising edge; outputs are sampled before the edge that consumes the inputs.
    task automatic cyc(input bit v, input logic [23:0] d, input logic [2:0] sel, input logic [1:0] mode,
                       input bit last, input bit mr,
                       output bit ifire, output bit mv, output logic [7:0] od, output bit ol);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_sel   = sel;
        bus.s_mode  = mode;
        bus.s_last  = last;
        bus.m_ready = mr;
        #1;
        ifire = v && bus.s_ready;
        mv    = bus.m_valid;
        od    = bus.m_data;
        ol    = bus.m_last;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'd0) begin errors++; $display("FAIL reset_m_data got %0d exp 0", bus.m_data); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", bus.m_last); end
        checks++; if (pix_count !== 24'd0) begin errors++; $display("FAIL reset_pix_count got %0d exp 0", pix_count); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", bus.s_ready); end
`ifdef CHX_THRESH_EN
        checks++; if (bus.m_bin !== 1'b0) begin errors++; $display("FAIL reset_m_bin got %b exp 0", bus.m_bin); end
`endif
    endtask

    task automatic test_select();
        bit ifire, mv, ol; logic [7:0] od;
        logic [7:0] exp_sel[3] = '{8'd255, 8'd128, 8'd64};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            cyc(1, PIX, 3'(s), 2'd0, 0, 1, ifire, mv, od, ol);
            checks++; if (ifire !== 1'b1) begin errors++; $display("FAIL select_accept sel=%0d got %b exp 1", s, ifire); end
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            checks++; if (mv !== 1'b0) begin errors++; $display("FAIL select_early_valid sel=%0d got %b exp 0", s, mv); end
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            checks++; if (mv !== 1'b1 || od !== exp_sel[s]) begin
                errors++; $display("FAIL select_data sel=%0d got valid=%b data=%0d exp valid=1 data=%0d", s, mv, od, exp_sel[s]);
            end
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        end
    endtask

    task automatic test_modes();
        bit ifire, mv, ol; logic [7:0] od;
        logic [1:0] modes[3] = '{2'd1, 2'd2, 2'd3};
        logic [2:0] sels[3]  = '{3'd0, 3'd0, 3'd1};
        logic [7:0] exps[3]  = '{8'd255, 8'd64, 8'd127};
        for (int i = 0; i < 3; i++) begin
            cyc(1, PIX, sels[i], modes[i], 0, 1, ifire, mv, od, ol);
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            checks++; if (mv !== 1'b1 || od !== exps[i]) begin
                errors++; $display("FAIL mode_data mode=%0d got valid=%b data=%0d exp valid=1 data=%0d", modes[i], mv, od, exps[i]);
            end
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        end
    endtask

    task automatic test_sel_err();
        bit ifire, mv, ol; logic [7:0] od;
        do_reset();
        cyc(1, PIX, 3'd3, 2'd0, 0, 1, ifire, mv, od, ol);
        cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        checks++; if (mv !== 1'b1 || od !== 8'd0) begin errors++; $display("FAIL oob_data got valid=%b data=%0d exp valid=1 data=0", mv, od); end
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL oob_sel_err got %b exp 1", sel_err); end
        for (int i = 0; i < 10; i++) cyc(1, 24'($urandom), 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        repeat (3) cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL oob_sticky got %b exp 1", sel_err); end
        do_reset();
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL oob_cleared got %b exp 0", sel_err); end
        // max mode ignores the select, even an out-of-range one
        cyc(1, PIX, 3'd7, 2'd1, 0, 1, ifire, mv, od, ol);
        cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        checks++; if (od !== 8'd255 || sel_err !== 1'b0) begin
            errors++; $display("FAIL oob_max got data=%0d sel_err=%b exp data=255 sel_err=0", od, sel_err);
        end
        cyc(1, PIX, 3'd3, 2'd3, 0, 1, ifire, mv, od, ol);
        cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        checks++; if (od !== 8'd0 || sel_err !== 1'b1) begin
            errors++; $display("FAIL oob_invert got data=%0d sel_err=%b exp data=0 sel_err=1", od, sel_err);
        end
        cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
    endtask

    task automatic test_stream();
        bit ifire, mv, ol, v, mr; logic [7:0] od;
        bit prev_stall = 0; logic [7:0] prev_od = '0;
        int sent = 0, rcvd = 0, extra = 0;
        do_reset();
        for (int n = 0; n < 400 && rcvd < 16; n++) begin
            v  = (sent < 16) && ($urandom_range(0, 2) != 0);
            mr = (n % 2) == 0;
            cyc(v, {16'($urandom), 8'(sent)}, 3'd0, 2'd0, 0, mr, ifire, mv, od, ol);
            if (prev_stall) begin
                checks++; if (mv !== 1'b1 || od !== prev_od) begin
                    errors++; $display("FAIL stream_stall_hold got valid=%b data=%0d exp valid=1 data=%0d", mv, od, prev_od);
                end
            end
            if (mv && mr) begin
                checks++; if (od !== 8'(rcvd)) begin errors++; $display("FAIL stream_order got %0d exp %0d", od, rcvd); end
                rcvd++;
            end
            if (ifire) sent++;
            prev_stall = mv && !mr;
            prev_od    = od;
        end
        for (int n = 0; n < 4; n++) begin
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            if (mv) extra++;
        end
        checks++; if (rcvd !== 16 || extra !== 0) begin
            errors++; $display("FAIL stream_count got rcvd=%0d extra=%0d exp rcvd=16 extra=0", rcvd, extra);
        end
    endtask

    task automatic test_frame();
        bit ifire, mv, ol; logic [7:0] od;
        int n = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cyc(c < 5, PIX, 3'(c % 3), 2'd0, c == 4, 1, ifire, mv, od, ol);
            if (mv) begin
                n++;
                checks++; if (pix_count !== 24'(n == 5 ? 0 : n)) begin
                    errors++; $display("FAIL frame_count beat=%0d got %0d exp %0d", n, pix_count, (n == 5 ? 0 : n));
                end
                checks++; if (ol !== (n == 5)) begin errors++; $display("FAIL frame_last beat=%0d got %b exp %b", n, ol, (n == 5)); end
            end
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL frame_outputs got %0d exp 5", n); end
    endtask

    task automatic test_random();
        bit ifire, mv, ol, v, mr, last; logic [7:0] od;
        logic [23:0] d; logic [2:0] sel; logic [1:0] mode;
        logic [8:0] q[$]; logic [8:0] e;
        int exp_cnt = 0; bit exp_err = 0;
        do_reset();
        for (int n = 0; n < 420; n++) begin
            v    = (n < 400) && ($urandom_range(0, 3) != 0);
            d    = 24'($urandom);
            sel  = 3'($urandom_range(0, 7));
            mode = 2'($urandom_range(0, 3));
            last = $urandom_range(0, 9) == 0;
            mr   = (n >= 400) || ($urandom_range(0, 3) != 0);
            cyc(v, d, sel, mode, last, mr, ifire, mv, od, ol);
            if (mv && mr) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected got data=%0d exp no output", od);
                end else begin
                    e = q.pop_front();
                    if ({ol, od} !== e) begin
                        errors++; $display("FAIL rand_data got last=%b data=%0d exp last=%b data=%0d", ol, od, e[8], e[7:0]);
                    end
                end
                exp_cnt = ol ? 0 : exp_cnt + 1;
            end
            if (ifire) begin
                q.push_back({last, ref_result(d, int'(sel), int'(mode))});
                if ((mode == 2'd0 || mode == 2'd3) && sel >= 3'd3) exp_err = 1;
            end
            checks++; if (pix_count !== 24'(exp_cnt)) begin errors++; $display("FAIL rand_count got %0d exp %0d", pix_count, exp_cnt); end
            checks++; if (sel_err !== exp_err) begin errors++; $display("FAIL rand_sel_err got %b exp %b", sel_err, exp_err); end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d pending exp 0", q.size()); end
    endtask

    task automatic test_reset_midstream();
        bit ifire, mv, ol; logic [7:0] od;
        int seen = 0;
        do_reset();
        cyc(1, PIX, 3'd0, 2'd0, 0, 0, ifire, mv, od, ol);
        cyc(1, PIX, 3'd1, 2'd0, 0, 0, ifire, mv, od, ol);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.m_valid !== 1'b0 || pix_count !== 24'd0) begin
            errors++; $display("FAIL midreset_state got valid=%b count=%0d exp valid=0 count=0", bus.m_valid, pix_count);
        end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL midreset_s_ready got %b exp 1", bus.s_ready); end
        for (int n = 0; n < 5; n++) begin
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            if (mv) seen++;
        end
        checks++; if (seen !== 0 || pix_count !== 24'd0) begin
            errors++; $display("FAIL midreset_flush got outputs=%0d count=%0d exp outputs=0 count=0", seen, pix_count);
        end
    endtask

`ifdef CHX_THRESH_EN
    task automatic test_thresh();
        bit ifire, mv, ol; logic [7:0] od;
        logic [7:0] vals[3] = '{8'd99, 8'd100, 8'd200};
        bit         bins[3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        bus.thresh = 8'd100;
        for (int i = 0; i < 3; i++) begin
            cyc(1, {16'h0, vals[i]}, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
            checks++; if (bus.m_valid !== 1'b1 || bus.m_bin !== bins[i]) begin
                errors++; $display("FAIL thresh_bin val=%0d got valid=%b bin=%b exp valid=1 bin=%b", vals[i], bus.m_valid, bus.m_bin, bins[i]);
            end
            cyc(0, '0, 3'd0, 2'd0, 0, 1, ifire, mv, od, ol);
        end
        bus.thresh = 8'd0;
    endtask
`endif

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sel   = '0;
        bus.s_mode  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
`ifdef CHX_THRESH_EN
        bus.thresh  = '0;
`endif
        test_reset();
        test_select();
        test_modes();
        test_sel_err();
        test_stream();
        test_frame();
        test_random();
        test_reset_midstream();
`ifdef CHX_THRESH_EN
        test_thresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
